// File: rtl/mux_scan_controller.sv
// Sequencer for the 8-to-1 datapath mux: drives a word onto inputs A..H, walks the select
// through every position, rebuilds the word from the sampled mux output and flags mismatches.
module mux_scan_controller #(
    parameter int SETTLE_CYCLES = 1,
    parameter bit DESCEND       = 1'b0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] DataIn,
    output logic [7:0] MuxIn,
    output logic [2:0] Sel,
    input  logic       MuxOut,
    output logic [7:0] DataOut,
    output logic       Busy,
    output logic       Done,
    output logic       Error
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_FINISH
    } state_t;

    localparam logic [2:0] SEL_FIRST   = DESCEND ? 3'd7 : 3'd0;
    localparam logic [2:0] SEL_LAST    = DESCEND ? 3'd0 : 3'd7;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] muxin_q, muxin_d;
    logic [7:0] dataout_q, dataout_d;
    logic [3:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       error_q, error_d;
    logic [7:0] cap_sel;

    // One-hot of the bit position currently addressed by the select.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cap_sel
            assign cap_sel[gi] = (sel_q == 3'(gi));
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        muxin_d   = muxin_q;
        dataout_d = dataout_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        error_d   = error_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    muxin_d   = DataIn;
                    dataout_d = 8'h00;
                    error_d   = 1'b0;
                    sel_d     = SEL_FIRST;
                    cnt_d     = 4'd0;
                    busy_d    = 1'b1;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                dataout_d = (dataout_q & ~cap_sel) | ({8{MuxOut}} & cap_sel);
                // The select stops at the final position; it never wraps.
                if (sel_q == SEL_LAST) begin
                    state_d = ST_FINISH;
                end else begin
                    sel_d   = DESCEND ? (sel_q - 3'd1) : (sel_q + 3'd1);
                    cnt_d   = 4'd0;
                    state_d = ST_SETTLE;
                end
            end
            ST_FINISH: begin
                busy_d  = 1'b0;
                error_d = (dataout_q != muxin_q);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= 3'd0;
            muxin_q   <= 8'h00;
            dataout_q <= 8'h00;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            muxin_q   <= muxin_d;
            dataout_q <= dataout_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
        end
    end

    assign MuxIn   = muxin_q;
    assign Sel     = sel_q;
    assign DataOut = dataout_q;
    assign Busy    = busy_q;
    assign Done    = (state_q == ST_FINISH);
    assign Error   = error_q;

endmodule

// File: tb/tb_mux_scan_controller.sv
// Bench for mux_scan_controller: two configurations (ascending/settle 1, descending/settle 3)
// checked every cycle against a scan-timeline model, plus directed literal checks.
module tb_mux_scan_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic [7:0] stuck;

    logic [7:0] muxin0, muxin1, dout0, dout1;
    logic [2:0] sel0, sel1;
    logic       mo0, mo1, busy0, busy1, done0, done1, err0, err1;

    // Mux models: ideal except for inputs forced low by the stuck mask.
    assign mo0 = muxin0[sel0] & ~stuck[sel0];
    assign mo1 = muxin1[sel1] & ~stuck[sel1];

    mux_scan_controller #(.SETTLE_CYCLES(1), .DESCEND(1'b0)) dut0 (
        .Clk(clk), .Reset(rst), .Start(start), .DataIn(din), .MuxIn(muxin0), .Sel(sel0),
        .MuxOut(mo0), .DataOut(dout0), .Busy(busy0), .Done(done0), .Error(err0)
    );

    mux_scan_controller #(.SETTLE_CYCLES(3), .DESCEND(1'b1)) dut1 (
        .Clk(clk), .Reset(rst), .Start(start), .DataIn(din), .MuxIn(muxin1), .Sel(sel1),
        .MuxOut(mo1), .DataOut(dout1), .Busy(busy1), .Done(done1), .Error(err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Model of each configuration, described by elapsed edges since the accepting edge.
    int         m_s[2]    = '{1, 3};
    bit         m_desc[2] = '{1'b0, 1'b1};
    bit         m_act[2];
    int         m_e[2];
    logic [7:0] m_word[2], m_mux[2], m_dout[2];
    logic [2:0] m_sel[2];
    logic       m_busy[2], m_done[2], m_err[2];
    bit         m_valid = 1'b0;

    logic [7:0] a_mux[2], a_dout[2];
    logic [2:0] a_sel[2];
    logic       a_busy[2], a_done[2], a_err[2];

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    function automatic logic [2:0] pos(input int d, input int j);
        return m_desc[d] ? 3'(7 - j) : 3'(j);
    endfunction

    task automatic model_step(input int d);
        int per, len, c;
        logic [2:0] p;
        per = m_s[d] + 1;
        len = 8 * per;
        if (rst) begin
            m_act[d] = 1'b0; m_sel[d] = 3'd0; m_mux[d] = 8'h00; m_dout[d] = 8'h00;
            m_busy[d] = 1'b0; m_done[d] = 1'b0; m_err[d] = 1'b0;
        end else if (!m_act[d]) begin
            m_done[d] = 1'b0;
            if (start) begin
                m_act[d] = 1'b1; m_e[d] = 0; m_word[d] = din; m_mux[d] = din;
                m_dout[d] = 8'h00; m_err[d] = 1'b0; m_busy[d] = 1'b1; m_sel[d] = pos(d, 0);
            end
        end else begin
            m_e[d]++;
            if (m_e[d] <= len) begin
                c = m_e[d] / per;
                m_sel[d] = pos(d, (c > 7) ? 7 : c);
                m_dout[d] = 8'h00;
                for (int j = 0; j < c; j++) begin
                    p = pos(d, j);
                    m_dout[d][p] = m_word[d][p] & ~stuck[p];
                end
                m_done[d] = (m_e[d] == len);
            end else begin
                m_act[d] = 1'b0; m_busy[d] = 1'b0; m_done[d] = 1'b0;
                m_err[d] = (m_dout[d] != m_word[d]);
            end
        end
    endtask

    // Compare on the falling edge, then advance the model with the inputs the next rising edge sees.
    initial begin
        forever begin
            @(negedge clk);
            a_mux[0] = muxin0; a_sel[0] = sel0; a_dout[0] = dout0;
            a_busy[0] = busy0; a_done[0] = done0; a_err[0] = err0;
            a_mux[1] = muxin1; a_sel[1] = sel1; a_dout[1] = dout1;
            a_busy[1] = busy1; a_done[1] = done1; a_err[1] = err1;
            if (m_valid) begin
                for (int d = 0; d < 2; d++) begin
                    chk("MuxIn", d, a_mux[d], m_mux[d]);
                    chk("Sel", d, a_sel[d], m_sel[d]);
                    chk("DataOut", d, a_dout[d], m_dout[d]);
                    chk("Busy", d, a_busy[d], m_busy[d]);
                    chk("Done", d, a_done[d], m_done[d]);
                    chk("Error", d, a_err[d], m_err[d]);
                end
            end
            for (int d = 0; d < 2; d++) model_step(d);
            if (rst) m_valid = 1'b1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        for (int i = 0; i < 100; i++) begin
            if (!m_act[0] && !m_act[1] && !busy0 && !busy1) return;
            tick;
        end
        chk("drain_timeout", 0, 1, 0);
    endtask

    // One scan on both DUTs; checks latency, reassembled word, Error after Done, select walk.
    task automatic run_scan(input logic [7:0] w, input logic [7:0] exp0, input logic [7:0] exp1,
                            input logic e0, input logic e1);
        int n0, n1;
        logic [7:0] d0, d1;
        n0 = -1; n1 = -1; d0 = 'x; d1 = 'x;
        start = 1'b1; din = w;
        tick;
        start = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            tick;
            if (n == 1)  begin chk("sel_first", 0, sel0, 3'd0); chk("sel_first", 1, sel1, 3'd7); end
            if (n == 3)  chk("sel_hold4", 1, sel1, 3'd7);
            if (n == 4)  chk("sel_step", 1, sel1, 3'd6);
            if (n == 15) chk("sel_last", 0, sel0, 3'd7);
            if (n == 28) chk("sel_last", 1, sel1, 3'd0);
            if (done0 && n0 < 0) begin n0 = n; d0 = dout0; chk("muxin_frozen", 0, muxin0, w); end
            if (done1 && n1 < 0) begin n1 = n; d1 = dout1; end
            if (n0 > 0 && n == n0 + 1) chk("error_after_done", 0, err0, e0);
            if (n1 > 0 && n == n1 + 1) chk("error_after_done", 1, err1, e1);
            if (n1 > 0 && n > n1 + 1) break;
        end
        chk("latency", 0, n0, 16);
        chk("latency", 1, n1, 32);
        chk("word_at_done", 0, d0, exp0);
        chk("word_at_done", 1, d1, exp1);
    endtask

    initial begin
        int t_done[$];
        logic [7:0] w_done[$];
        int c0, c1;
        rst = 1'b1; start = 1'b0; din = 8'h00; stuck = 8'h00;
        repeat (3) tick;
        chk("reset_sel", 1, sel1, 3'd0);
        chk("reset_busy", 0, busy0, 1'b0);
        rst = 1'b0;
        tick;

        run_scan(8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b0);
        run_scan(8'h81, 8'h81, 8'h81, 1'b0, 1'b0);

        stuck = 8'h04;
        run_scan(8'hFF, 8'hFB, 8'hFB, 1'b1, 1'b1);
        tick;
        chk("error_held", 0, err0, 1'b1);
        stuck = 8'h00;

        // Start held high: back-to-back scans, new word after first acceptance.
        start = 1'b1; din = 8'h00;
        tick;
        din = 8'hFF;
        for (int n = 1; n <= 40; n++) begin
            tick;
            if (done0) begin t_done.push_back(n); w_done.push_back(dout0); end
            if (n == 17) chk("b2b_error", 0, err0, 1'b0);
            if (n == 35) chk("b2b_error", 0, err0, 1'b0);
        end
        start = 1'b0;
        chk("b2b_pulses", 0, t_done.size(), 2);
        if (t_done.size() >= 2) begin
            chk("b2b_first", 0, t_done[0], 16);
            chk("b2b_gap", 0, t_done[1] - t_done[0], 18);
            chk("b2b_word0", 0, w_done[0], 8'h00);
            chk("b2b_word1", 0, w_done[1], 8'hFF);
        end
        drain;

        // Reset in the middle of a scan.
        start = 1'b1; din = 8'h3C;
        tick;
        start = 1'b0;
        repeat (6) tick;
        rst = 1'b1;
        tick;
        chk("abort_busy", 0, busy0, 1'b0);
        chk("abort_sel", 0, sel0, 3'd0);
        chk("abort_muxin", 0, muxin0, 8'h00);
        chk("abort_dout", 0, dout0, 8'h00);
        chk("abort_sel", 1, sel1, 3'd0);
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick;
            chk("abort_no_done", 0, done0, 1'b0);
            chk("abort_no_done", 1, done1, 1'b0);
        end

        // Start pulsed again mid-scan with a different word: must be ignored.
        c0 = 0; c1 = 0;
        start = 1'b1; din = 8'h96;
        tick;
        start = 1'b0;
        repeat (4) tick;
        start = 1'b1; din = 8'h11;
        tick;
        start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick;
            if (done0) begin c0++; chk("ignore_word", 0, dout0, 8'h96); end
            if (done1) begin c1++; chk("ignore_word", 1, dout1, 8'h96); end
        end
        chk("ignore_pulses", 0, c0, 1);
        chk("ignore_pulses", 1, c1, 1);
        drain;

        // Random traffic; the stuck input only changes while neither scan is running.
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 3) == 0);
            din   = 8'($urandom);
            if (!m_act[0] && !m_act[1] && $urandom_range(0, 7) == 0)
                stuck = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
            tick;
        end
        rst = 1'b0; start = 1'b0;
        drain;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
